alu_arbiter: RTL

Sequencer and two-port arbiter for the shared 32-bit ALU. It accepts operation requests from two independent requesters over valid/ready handshakes and selects one per transaction, round-robin by default. It drives the combinational ALU from registered operands, captures the result one cycle later, and returns it on the winning requester's private response channel. Opcodes the ALU does not implement are rejected with an error flag and are never issued.

---
 rtl/alu_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter and sequencer for the shared 32-bit ALU.
// Latency: accept in cycle t, resp_valid in cycle t+2; one op in flight, 3-cycle minimum issue interval.
// Backpressure: response held stable until resp_ready of the granted port; no request accepted meanwhile.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [OP_W-1:0]  req_op0,
    input  logic [OP_W-1:0]  req_op1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_cout,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_control,
    input  logic [WIDTH-1:0] alu_dout,
    input  logic             alu_cout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             grant_q;
    logic             err_q;
    logic             arith_q;
    logic [1:0]       resp_valid_q;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_cout_q;
    logic             resp_err_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [OP_W-1:0]  alu_control_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic             last_grant_q;
`endif

    logic             win_d;
    logic [OP_W-1:0]  op_d;
    logic             illegal_d;
    logic             arith_d;

    // Pick the winner among valid requesters and decode its opcode.
    always_comb begin
        win_d = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        win_d = ~req_valid[0];
`else
        if (&req_valid) begin
            win_d = ~last_grant_q;
        end else begin
            win_d = req_valid[1];
        end
`endif
        op_d      = win_d ? req_op1 : req_op0;
        // Opcodes with both upper bits set are illegal.
        illegal_d = op_d[2] & op_d[1];
        // Only ADD/SUB produce a meaningful carry; the ALU leaves it stale otherwise.
        arith_d   = op_d[2] & ~op_d[1];
    end

    assign req_ready   = (state_q == S_IDLE && |req_valid) ? (win_d ? 2'b10 : 2'b01) : 2'b00;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_cout   = resp_cout_q;
    assign resp_err    = resp_err_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_control_q;

    // Sequencer FSM: accept -> drive ALU -> capture result -> hold response until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            grant_q       <= 1'b0;
            err_q         <= 1'b0;
            arith_q       <= 1'b0;
            resp_valid_q  <= 2'b00;
            resp_data_q   <= '0;
            resp_cout_q   <= 1'b0;
            resp_err_q    <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_control_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req_valid) begin
                        alu_a_q       <= win_d ? req_a1 : req_a0;
                        alu_b_q       <= win_d ? req_b1 : req_b0;
                        // Illegal ops still go through EXEC but the ALU sees a harmless control.
                        alu_control_q <= illegal_d ? '0 : op_d;
                        err_q         <= illegal_d;
                        arith_q       <= arith_d;
                        grant_q       <= win_d;
                        state_q       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_data_q  <= err_q ? '0 : alu_dout;
                    resp_cout_q  <= arith_q & ~err_q & alu_cout;
                    resp_err_q   <= err_q;
                    resp_valid_q <= grant_q ? 2'b10 : 2'b01;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready[grant_q]) begin
                        resp_valid_q <= 2'b00;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant_q <= grant_q;
`endif
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
